// File: rtl/nor3_sweep_checker.sv
// Exhaustive 64-vector sweep checker for a downstream 3-bit NOR stage.
// Drives every (a,b) pair, holds it SETTLE cycles, then compares y_in against ~(a|b).
module nor3_sweep_checker #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [2:0] a_out,
   output logic [2:0] b_out,
   input  logic [2:0] y_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] mismatch_cnt,
   output logic [2:0] err_bits,
   output logic       fail_valid,
   output logic [2:0] first_fail_a,
   output logic [2:0] first_fail_b,
   output logic [2:0] first_fail_y
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic [3:0] settle_cnt_q, settle_cnt_d;
   logic [2:0] a_out_q, a_out_d;
   logic [2:0] b_out_q, b_out_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [6:0] mismatch_cnt_q, mismatch_cnt_d;
   logic [2:0] err_bits_q, err_bits_d;
   logic       fail_valid_q, fail_valid_d;
   logic [2:0] first_fail_a_q, first_fail_a_d;
   logic [2:0] first_fail_b_q, first_fail_b_d;
   logic [2:0] first_fail_y_q, first_fail_y_d;

   logic       start_acc;
   logic [2:0] expected;
   logic       mismatch;

   // Status flags lag the FSM by one cycle, so start is also gated on the
   // visible busy flag to keep "ignored while busy" true at the port.
   assign start_acc = start && !busy_q && (state_q == IDLE || state_q == DONE);
   assign expected  = ~(a_out_q | b_out_q);
   assign mismatch  = (state_q == SAMPLE) && (y_in != expected);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         settle_cnt_q   <= '0;
         a_out_q        <= '0;
         b_out_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         mismatch_cnt_q <= '0;
         err_bits_q     <= '0;
         fail_valid_q   <= 1'b0;
         first_fail_a_q <= '0;
         first_fail_b_q <= '0;
         first_fail_y_q <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         settle_cnt_q   <= settle_cnt_d;
         a_out_q        <= a_out_d;
         b_out_q        <= b_out_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         err_bits_q     <= err_bits_d;
         fail_valid_q   <= fail_valid_d;
         first_fail_a_q <= first_fail_a_d;
         first_fail_b_q <= first_fail_b_d;
         first_fail_y_q <= first_fail_y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start_acc) state_d = DRIVE;
         DRIVE:      if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
         SAMPLE:     state_d = (idx_q == 6'd63) ? DONE : DRIVE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d          = idx_q;
      settle_cnt_d   = '0;
      mismatch_cnt_d = mismatch_cnt_q;
      err_bits_d     = err_bits_q;
      fail_valid_d   = fail_valid_q;
      first_fail_a_d = first_fail_a_q;
      first_fail_b_d = first_fail_b_q;
      first_fail_y_d = first_fail_y_q;

      if (start_acc) begin
         idx_d          = '0;
         mismatch_cnt_d = '0;
         err_bits_d     = '0;
         fail_valid_d   = 1'b0;
         first_fail_a_d = '0;
         first_fail_b_d = '0;
         first_fail_y_d = '0;
      end

      if (state_q == DRIVE && state_d == DRIVE) settle_cnt_d = settle_cnt_q + 4'd1;

      if (state_q == SAMPLE) begin
         if (idx_q != 6'd63) idx_d = idx_q + 6'd1;
         if (mismatch) begin
            mismatch_cnt_d = mismatch_cnt_q + 7'd1;
            err_bits_d     = err_bits_q | (y_in ^ expected);
            if (!fail_valid_q) begin
               fail_valid_d   = 1'b1;
               first_fail_a_d = a_out_q;
               first_fail_b_d = b_out_q;
               first_fail_y_d = y_in;
            end
         end
      end

      a_out_d = '0;
      b_out_d = '0;
      if (state_d == DRIVE || state_d == SAMPLE) begin
         a_out_d = idx_d[5:3];
         b_out_d = idx_d[2:0];
      end

      busy_d = start_acc || state_q == DRIVE || state_q == SAMPLE;
      done_d = (state_q == DONE) && !start_acc;
   end

   assign a_out        = a_out_q;
   assign b_out        = b_out_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = done_q && (mismatch_cnt_q == 7'd0);
   assign mismatch_cnt = mismatch_cnt_q;
   assign err_bits     = err_bits_q;
   assign fail_valid   = fail_valid_q;
   assign first_fail_a = first_fail_a_q;
   assign first_fail_b = first_fail_b_q;
   assign first_fail_y = first_fail_y_q;

endmodule

// File: tb/tb_nor3_sweep_checker.sv
// Directed bench for nor3_sweep_checker: SETTLE=1 instance with a faultable
// loopback, plus a SETTLE=3 instance with a clean loopback.
module tb_nor3_sweep_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0, start3 = 1'b0;
   logic [1:0] mode = 2'd0;

   logic [2:0] a1, b1, y1, a3, b3, y3;
   logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
   logic [6:0] cnt1, cnt3;
   logic [2:0] err1, ffa1, ffb1, ffy1, err3, ffa3, ffb3, ffy3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Loopback: 0 = correct NOR, 1 = y[0] stuck at 0, 2 = all bits inverted
   always_comb begin
      case (mode)
         2'd1:    y1 = ~(a1 | b1) & 3'b110;
         2'd2:    y1 = a1 | b1;
         default: y1 = ~(a1 | b1);
      endcase
   end
   assign y3 = ~(a3 | b3);

   nor3_sweep_checker #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1), .err_bits(err1),
      .fail_valid(fv1), .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_y(ffy1)
   );

   nor3_sweep_checker #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3), .y_in(y3),
      .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3), .err_bits(err3),
      .fail_valid(fv3), .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_y(ffy3)
   );

   // Start accepted at the next edge; returns edges counted until done is seen.
   task automatic run1(output int lat);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         if (done1) break;
      end
   endtask

   task automatic test_reset;
      logic [28:0] o1, o3;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      o1 = {a1, b1, busy1, done1, pass1, cnt1, err1, fv1, ffa1, ffb1, ffy1};
      o3 = {a3, b3, busy3, done3, pass3, cnt3, err3, fv3, ffa3, ffb3, ffy3};
      checks++;
      if (o1 !== '0) begin failures++; $display("FAIL reset_outs1 got=%h want=0", o1); end
      checks++;
      if (o3 !== '0) begin failures++; $display("FAIL reset_outs3 got=%h want=0", o3); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy1, done1, a1, b1} !== '0) begin
         failures++; $display("FAIL idle_hold got=%b want=0", {busy1, done1, a1, b1});
      end
   endtask

   task automatic test_pass;
      int lat;
      mode = 2'd0;
      run1(lat);
      checks++;
      if (lat !== 129) begin failures++; $display("FAIL pass_latency got=%0d want=129", lat); end
      checks++;
      if ({pass1, busy1, cnt1, err1, fv1, a1, b1} !== {1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 3'd0, 3'd0}) begin
         failures++;
         $display("FAIL pass_results pass=%b busy=%b cnt=%0d err=%b fv=%b a=%0d b=%0d want pass=1 rest 0",
                  pass1, busy1, cnt1, err1, fv1, a1, b1);
      end
   endtask

   task automatic test_stuck;
      int lat;
      mode = 2'd1;
      run1(lat);
      checks++;
      if (lat !== 129) begin failures++; $display("FAIL stuck_latency got=%0d want=129", lat); end
      checks++;
      if (cnt1 !== 7'd16) begin failures++; $display("FAIL stuck_cnt got=%0d want=16", cnt1); end
      checks++;
      if (err1 !== 3'b001) begin failures++; $display("FAIL stuck_err got=%b want=001", err1); end
      checks++;
      if ({fv1, ffa1, ffb1, ffy1, pass1} !== {1'b1, 3'b000, 3'b000, 3'b110, 1'b0}) begin
         failures++;
         $display("FAIL stuck_first fv=%b a=%b b=%b y=%b pass=%b want 1 000 000 110 0",
                  fv1, ffa1, ffb1, ffy1, pass1);
      end
   endtask

   task automatic test_invert;
      int lat;
      mode = 2'd2;
      run1(lat);
      checks++;
      if ({cnt1, err1} !== {7'd64, 3'b111}) begin
         failures++; $display("FAIL invert_cnt_err cnt=%0d err=%b want 64 111", cnt1, err1);
      end
      checks++;
      if ({fv1, ffa1, ffb1, ffy1, pass1} !== {1'b1, 9'd0, 1'b0}) begin
         failures++;
         $display("FAIL invert_first fv=%b a=%b b=%b y=%b pass=%b want 1 000 000 000 0",
                  fv1, ffa1, ffb1, ffy1, pass1);
      end
   endtask

   task automatic test_settle3;
      int lat;
      int bad_hold;
      bad_hold = 0;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      lat = 0;
      // After accept edge k, vector k/4 must be on the outputs
      if ({a3, b3} !== 6'd0) bad_hold++;
      while (lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         if (lat < 48 && {a3, b3} !== 6'(lat / 4)) bad_hold++;
         if (done3) break;
      end
      checks++;
      if (bad_hold !== 0) begin failures++; $display("FAIL settle3_hold got=%0d bad cycles want=0", bad_hold); end
      checks++;
      if (lat !== 257) begin failures++; $display("FAIL settle3_latency got=%0d want=257", lat); end
      checks++;
      if ({pass3, cnt3, err3, fv3} !== {1'b1, 7'd0, 3'd0, 1'b0}) begin
         failures++; $display("FAIL settle3_results pass=%b cnt=%0d err=%b fv=%b", pass3, cnt3, err3, fv3);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      logic [28:0] o1;
      mode = 2'd1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if ({a1, b1, cnt1, busy1} !== {3'd2, 3'd4, 7'd6, 1'b1}) begin
         failures++; $display("FAIL mid_state a=%0d b=%0d cnt=%0d busy=%b want 2 4 6 1", a1, b1, cnt1, busy1);
      end
      rst = 1'b1;
      start1 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start1 = 1'b0;
      o1 = {a1, b1, busy1, done1, pass1, cnt1, err1, fv1, ffa1, ffb1, ffy1};
      checks++;
      if (o1 !== '0) begin failures++; $display("FAIL mid_reset_outs got=%h want=0", o1); end
      run1(lat);
      checks++;
      if ({lat[7:0], cnt1, err1, ffy1, fv1} !== {8'd129, 7'd16, 3'b001, 3'b110, 1'b1}) begin
         failures++;
         $display("FAIL mid_rerun lat=%0d cnt=%0d err=%b y=%b fv=%b want 129 16 001 110 1",
                  lat, cnt1, err1, ffy1, fv1);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      mode = 2'd1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         start1 = (lat == 10 || lat == 60 || lat == 127 || lat == 128);
         if (done1) break;
      end
      start1 = 1'b0;
      checks++;
      if ({lat[7:0], cnt1, fv1} !== {8'd129, 7'd16, 1'b1}) begin
         failures++; $display("FAIL busy_ignore lat=%0d cnt=%0d fv=%b want 129 16 1", lat, cnt1, fv1);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({done1, cnt1, err1, fv1} !== {1'b1, 7'd16, 3'b001, 1'b1}) begin
         failures++; $display("FAIL done_hold done=%b cnt=%0d err=%b fv=%b", done1, cnt1, err1, fv1);
      end
      mode = 2'd0;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      checks++;
      if ({done1, busy1, cnt1, err1, fv1, ffy1} !== {1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL restart_clear done=%b busy=%b cnt=%0d err=%b fv=%b y=%b",
                  done1, busy1, cnt1, err1, fv1, ffy1);
      end
      lat = 0;
      while (lat < 3000 && !done1) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if ({lat[7:0], pass1} !== {8'd129, 1'b1}) begin
         failures++; $display("FAIL restart_pass lat=%0d pass=%b want 129 1", lat, pass1);
      end
   endtask

   initial begin
      test_reset;
      test_pass;
      test_stuck;
      test_invert;
      test_settle3;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
